// File: rtl/lcd_line_scheduler.sv
// Round-robin scheduler that shares one I2C text-LCD byte sender between two
// clients, sending a DDRAM address command followed by one line of characters.
module lcd_line_scheduler #(
    parameter int unsigned CHARS        = 16,
    parameter int unsigned BUSY_TIMEOUT = 1_000_000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 lcd_ready,
    input  logic                 req_a,
    input  logic                 req_b,
    input  logic                 line_a,
    input  logic                 line_b,
    input  logic [8*CHARS-1:0]   text_a,
    input  logic [8*CHARS-1:0]   text_b,
    output logic                 grant_a,
    output logic                 grant_b,
    output logic                 done_a,
    output logic                 done_b,
    output logic                 err,
    output logic [1:0]           owner,
    output logic                 lcd_send,
    output logic                 lcd_rs,
    output logic [7:0]           lcd_byte,
    input  logic                 lcd_busy
);

    localparam int unsigned TEXT_W = 8 * CHARS;
    localparam int unsigned IDX_W  = $clog2(CHARS + 1);
    localparam int unsigned CNT_W  = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHARS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TEXT_W-1:0]   text_q, text_d;
    logic                line_q, line_d;
    logic                last_b_q, last_b_d;
    logic [1:0]          owner_d;
    logic                send_d, rs_d;
    logic [7:0]          byte_d;
    logic                grant_a_d, grant_b_d, done_a_d, done_b_d, err_d;
    logic                arb_go, arb_b;
    logic                end_xfer, timeout;

    // Byte k of a transfer: 0 is the set-address command, k>0 is char k-1.
    function automatic logic [7:0] byte_at(input logic [IDX_W-1:0] k,
                                           input logic [TEXT_W-1:0] t,
                                           input logic ln);
        logic [7:0] b;
        b = ln ? 8'hC0 : 8'h80;
        for (int unsigned i = 0; i < CHARS; i++) begin
            if (k == IDX_W'(i + 1)) b = t[8*i +: 8];
        end
        return b;
    endfunction

    // On a tie the client that was not served last wins.
    assign arb_go = ((state_q == IDLE) || (state_q == DONE)) && lcd_ready &&
                    !lcd_busy && (req_a || req_b);
    assign arb_b  = req_b && (!req_a || !last_b_q);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        text_d    = text_q;
        line_d    = line_q;
        last_b_d  = last_b_q;
        owner_d   = owner;
        send_d    = 1'b0;
        rs_d      = lcd_rs;
        byte_d    = lcd_byte;
        grant_a_d = 1'b0;
        grant_b_d = 1'b0;
        done_a_d  = 1'b0;
        done_b_d  = 1'b0;
        err_d     = 1'b0;
        end_xfer  = 1'b0;
        timeout   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (arb_go) begin
                    state_d   = ISSUE;
                    idx_d     = '0;
                    cnt_d     = '0;
                    owner_d   = arb_b ? 2'b10 : 2'b01;
                    grant_a_d = !arb_b;
                    grant_b_d = arb_b;
                    text_d    = arb_b ? text_b : text_a;
                    line_d    = arb_b ? line_b : line_a;
                    byte_d    = line_d ? 8'hC0 : 8'h80;
                    rs_d      = 1'b0;
                end
            end
            ISSUE: begin
                if (lcd_busy) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    end_xfer = 1'b1;
                    timeout  = 1'b1;
                end else begin
                    send_d = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (!lcd_busy) begin
                    if (idx_q == IDX_LAST) begin
                        end_xfer = 1'b1;
                    end else begin
                        state_d = ISSUE;
                        idx_d   = idx_q + 1'b1;
                        cnt_d   = '0;
                        byte_d  = byte_at(idx_d, text_q, line_q);
                        rs_d    = 1'b1;
                        send_d  = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    end_xfer = 1'b1;
                    timeout  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Normal end goes through DONE; an abort returns straight to IDLE.
        if (end_xfer) begin
            state_d  = timeout ? IDLE : DONE;
            send_d   = 1'b0;
            cnt_d    = '0;
            done_a_d = owner[0];
            done_b_d = owner[1];
            err_d    = timeout;
            last_b_d = owner[1];
            owner_d  = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            text_q   <= '0;
            line_q   <= 1'b0;
            last_b_q <= 1'b1;
            owner    <= 2'b00;
            lcd_send <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_byte <= 8'h00;
            grant_a  <= 1'b0;
            grant_b  <= 1'b0;
            done_a   <= 1'b0;
            done_b   <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            text_q   <= text_d;
            line_q   <= line_d;
            last_b_q <= last_b_d;
            owner    <= owner_d;
            lcd_send <= send_d;
            lcd_rs   <= rs_d;
            lcd_byte <= byte_d;
            grant_a  <= grant_a_d;
            grant_b  <= grant_b_d;
            done_a   <= done_a_d;
            done_b   <= done_b_d;
            err      <= err_d;
        end
    end

endmodule

// File: tb/tb_lcd_line_scheduler.sv
// Scoreboard bench for lcd_line_scheduler: a sender model pops expected bytes
// from a queue filled by each scenario task.
module tb_lcd_line_scheduler;

    localparam int unsigned CHARS  = 16;
    localparam int unsigned TO     = 100;
    localparam int          BUDGET = 3000;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b1;
    logic                 lcd_ready, req_a, req_b, line_a, line_b;
    logic [8*CHARS-1:0]   text_a, text_b;
    logic                 grant_a, grant_b, done_a, done_b, err;
    logic [1:0]           owner;
    logic                 lcd_send, lcd_rs;
    logic [7:0]           lcd_byte;
    logic                 lcd_busy;

    int          checks = 0;
    int          errors = 0;
    logic [8:0]  exp_q[$];
    logic [8:0]  sb_exp;
    int          hs_count = 0;
    bit          stuck = 1'b0;
    int          btime = 2;
    int          bcnt = 0;

    always #5 clk = ~clk;

    lcd_line_scheduler #(.CHARS(CHARS), .BUSY_TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .lcd_ready(lcd_ready),
        .req_a(req_a), .req_b(req_b), .line_a(line_a), .line_b(line_b),
        .text_a(text_a), .text_b(text_b),
        .grant_a(grant_a), .grant_b(grant_b), .done_a(done_a), .done_b(done_b),
        .err(err), .owner(owner), .lcd_send(lcd_send), .lcd_rs(lcd_rs),
        .lcd_byte(lcd_byte), .lcd_busy(lcd_busy)
    );

    function automatic logic [8*CHARS-1:0] str2text(input string s);
        logic [8*CHARS-1:0] t;
        t = '0;
        for (int i = 0; i < CHARS; i++) t[8*i +: 8] = (i < s.len()) ? s[i] : 8'h20;
        return t;
    endfunction

    task automatic push_line(input logic ln, input logic [8*CHARS-1:0] t, input int nchars);
        exp_q.push_back({1'b0, ln ? 8'hC0 : 8'h80});
        for (int i = 0; i < nchars; i++) exp_q.push_back({1'b1, t[8*i +: 8]});
    endtask

    // Byte sender: latches a byte on send, then holds busy for btime cycles.
    task automatic sender_model();
        forever begin
            @(negedge clk or negedge reset_n);
            if (!reset_n) begin
                lcd_busy = 1'b0;
                bcnt = 0;
            end else if (stuck) begin
                lcd_busy = 1'b0;
            end else if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) lcd_busy = 1'b0;
            end else if (lcd_send && !lcd_busy) begin
                hs_count++;
                lcd_busy = 1'b1;
                bcnt = btime;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_byte: got rs=%0b byte=%h, none expected", lcd_rs, lcd_byte);
                end else begin
                    sb_exp = exp_q.pop_front();
                    if ({lcd_rs, lcd_byte} !== sb_exp) begin
                        errors++;
                        $display("FAIL sb_byte: got rs=%0b byte=%h, expected rs=%0b byte=%h",
                                 lcd_rs, lcd_byte, sb_exp[8], sb_exp[7:0]);
                    end
                end
            end
        end
    endtask

    task automatic wait_grant(output bit got, output int cyc);
        got = 1'b0;
        cyc = 0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            cyc++;
            if (grant_a || grant_b) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (done_a || done_b) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        lcd_ready = 1'b1; req_a = 1'b0; req_b = 1'b0;
        line_a = 1'b0; line_b = 1'b0; text_a = '0; text_b = '0;
        #1 reset_n = 1'b0;
        #3;
        checks++;
        if ({grant_a, grant_b, done_a, done_b, err, lcd_send, lcd_rs} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctl: got %b, expected 0000000",
                     {grant_a, grant_b, done_a, done_b, err, lcd_send, lcd_rs});
        end
        checks++;
        if (owner !== 2'b00 || lcd_byte !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got owner=%b byte=%h, expected 00/00", owner, lcd_byte);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [8*CHARS-1:0] ta;
        bit got; int cyc;
        btime = 2; hs_count = 0;
        ta = str2text("HELLO WORLD 1234");
        text_a = ta; line_a = 1'b0;
        push_line(1'b0, ta, CHARS);
        req_a = 1'b1;
        wait_grant(got, cyc);
        checks++;
        if (!got || grant_a !== 1'b1 || grant_b !== 1'b0 || cyc !== 1) begin
            errors++;
            $display("FAIL single_grant: got a=%b b=%b after %0d cycles, expected a=1 b=0 after 1",
                     grant_a, grant_b, cyc);
        end
        checks++;
        if (owner !== 2'b01) begin
            errors++;
            $display("FAIL single_owner: got %b, expected 01", owner);
        end
        req_a = 1'b0;
        @(negedge clk);
        checks++;
        if (lcd_send !== 1'b1 || lcd_rs !== 1'b0 || lcd_byte !== 8'h80) begin
            errors++;
            $display("FAIL single_first_send: got send=%b rs=%b byte=%h, expected 1/0/80",
                     lcd_send, lcd_rs, lcd_byte);
        end
        wait_done(got);
        checks++;
        if (!got || done_a !== 1'b1 || done_b !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got done_a=%b done_b=%b err=%b, expected 1/0/0",
                     done_a, done_b, err);
        end
        @(negedge clk);
        checks++;
        if (owner !== 2'b00) begin
            errors++;
            $display("FAIL single_owner_clr: got %b, expected 00", owner);
        end
        checks++;
        if (hs_count !== CHARS + 1 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL single_count: got %0d handshakes, %0d left, expected 17, 0",
                     hs_count, exp_q.size());
        end
    endtask

    task automatic test_tie();
        logic [8*CHARS-1:0] ta, tb;
        bit got; int cyc; bit want_b;
        btime = 1;
        ta = str2text("CLOCK 12:34:56  ");
        tb = str2text("STOPWATCH 00:07 ");
        text_a = ta; text_b = tb; line_a = 1'b0; line_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) push_line(1'b0, ta, CHARS);
            else            push_line(1'b1, tb, CHARS);
        end
        req_a = 1'b1; req_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            want_b = (k % 2 == 1);
            wait_grant(got, cyc);
            checks++;
            if (!got || grant_a !== !want_b || grant_b !== want_b || cyc !== 1) begin
                errors++;
                $display("FAIL tie_grant%0d: got a=%b b=%b after %0d cycles, expected b=%b after 1",
                         k, grant_a, grant_b, cyc, want_b);
            end
            if (k == 3) begin
                req_a = 1'b0; req_b = 1'b0;
            end
            wait_done(got);
            checks++;
            if (!got || done_a !== !want_b || done_b !== want_b) begin
                errors++;
                $display("FAIL tie_done%0d: got a=%b b=%b, expected b=%b", k, done_a, done_b, want_b);
            end
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL tie_left: got %0d bytes pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_not_ready();
        logic [8*CHARS-1:0] ta;
        bit bad; bit got;
        btime = 3;
        ta = str2text("READY GATE TEST ");
        text_a = ta; line_a = 1'b0;
        lcd_ready = 1'b0;
        req_a = 1'b1;
        bad = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (grant_a || grant_b || lcd_send) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL not_ready_idle: got activity while lcd_ready=0, expected none");
        end
        push_line(1'b0, ta, CHARS);
        lcd_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (grant_a !== 1'b1) begin
            errors++;
            $display("FAIL ready_grant: got %b, expected 1", grant_a);
        end
        req_a = 1'b0;
        @(negedge clk);
        checks++;
        if (lcd_send !== 1'b1) begin
            errors++;
            $display("FAIL ready_send: got %b, expected 1", lcd_send);
        end
        wait_done(got);
        checks++;
        if (!got || done_a !== 1'b1) begin
            errors++;
            $display("FAIL ready_done: got %b, expected 1", done_a);
        end
    endtask

    task automatic test_snapshot();
        logic [8*CHARS-1:0] ta;
        bit got; int cyc;
        btime = 2;
        ta = str2text("SNAPSHOT LINE 2!");
        text_a = ta; line_a = 1'b1;
        push_line(1'b1, ta, CHARS);
        req_a = 1'b1;
        wait_grant(got, cyc);
        @(negedge clk);
        text_a = str2text("CORRUPTED TEXT..");
        line_a = 1'b0;
        req_a = 1'b0;
        wait_done(got);
        checks++;
        if (!got || done_a !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL snap_done: got done_a=%b err=%b, expected 1/0", done_a, err);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL snap_left: got %0d bytes pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_timeout();
        logic [8*CHARS-1:0] ta;
        bit got; int cyc; int n; logic last_send;
        ta = str2text("AFTER TIMEOUT OK");
        text_a = ta; line_a = 1'b0;
        stuck = 1'b1;
        req_a = 1'b1;
        wait_grant(got, cyc);
        req_a = 1'b0;
        n = 0; last_send = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            n++;
            if (done_a || done_b || err) break;
            last_send = lcd_send;
        end
        checks++;
        if (err !== 1'b1 || done_a !== 1'b1 || done_b !== 1'b0) begin
            errors++;
            $display("FAIL to_pulse: got err=%b done_a=%b done_b=%b, expected 1/1/0", err, done_a, done_b);
        end
        checks++;
        if (n !== TO) begin
            errors++;
            $display("FAIL to_cycles: got %0d, expected %0d", n, TO);
        end
        checks++;
        if (lcd_send !== 1'b0 || last_send !== 1'b1) begin
            errors++;
            $display("FAIL to_send: got now=%b before=%b, expected 0/1", lcd_send, last_send);
        end
        stuck = 1'b0;
        @(negedge clk);
        checks++;
        if (owner !== 2'b00) begin
            errors++;
            $display("FAIL to_owner: got %b, expected 00", owner);
        end
        push_line(1'b0, ta, CHARS);
        req_a = 1'b1;
        wait_grant(got, cyc);
        req_a = 1'b0;
        wait_done(got);
        checks++;
        if (!got || done_a !== 1'b1 || err !== 1'b0 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL to_recover: got done_a=%b err=%b left=%0d, expected 1/0/0",
                     done_a, err, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [8*CHARS-1:0] ta;
        bit got; int cyc;
        btime = 2; hs_count = 0;
        ta = str2text("RESET MID XFER  ");
        text_a = ta; line_a = 1'b0;
        push_line(1'b0, ta, 5);
        req_a = 1'b1;
        wait_grant(got, cyc);
        req_a = 1'b0;
        for (int i = 0; i < BUDGET && hs_count < 6; i++) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({grant_a, grant_b, done_a, done_b, err, lcd_send, lcd_rs} !== 7'b0 ||
            owner !== 2'b00 || lcd_byte !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: got ctl=%b owner=%b byte=%h, expected 0/00/00",
                     {grant_a, grant_b, done_a, done_b, err, lcd_send, lcd_rs}, owner, lcd_byte);
        end
        checks++;
        if (hs_count !== 6 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL mid_progress: got %0d handshakes, %0d left, expected 6, 0",
                     hs_count, exp_q.size());
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        hs_count = 0;
        push_line(1'b0, ta, CHARS);
        req_a = 1'b1;
        wait_grant(got, cyc);
        req_a = 1'b0;
        @(negedge clk);
        checks++;
        if (lcd_send !== 1'b1 || lcd_rs !== 1'b0 || lcd_byte !== 8'h80) begin
            errors++;
            $display("FAIL mid_restart: got send=%b rs=%b byte=%h, expected 1/0/80",
                     lcd_send, lcd_rs, lcd_byte);
        end
        wait_done(got);
        checks++;
        if (!got || done_a !== 1'b1 || hs_count !== CHARS + 1 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL mid_complete: got done_a=%b hs=%0d left=%0d, expected 1/17/0",
                     done_a, hs_count, exp_q.size());
        end
    endtask

    initial begin
        lcd_busy = 1'b0;
        fork
            sender_model();
        join_none
        test_reset();
        test_tie();
        test_single();
        test_not_ready();
        test_snapshot();
        test_timeout();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_line_scheduler.md
# lcd_line_scheduler

Shares the I2C text-LCD byte sender between two display clients. Each client requests a full-line rewrite. The scheduler arbitrates round-robin, snapshots the winner's text, and sequences the DDRAM set-address command followed by CHARS data bytes through the sender's send/busy handshake. It sits between the watch display sources (e.g. clock and stopwatch) and the LCD byte-send block, and stays idle until LCD initialisation is complete.

## Interface
- CHARS, 16, characters per line; data bytes sent per request.
- BUSY_TIMEOUT, 1_000_000, clk cycles allowed per handshake phase before abort.

- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- lcd_ready  in  1  LCD init done; no request is granted while 0.
- req_a / req_b  in  1  level request, client A / B.
- line_a / line_b  in  1  target line (0: top, 1: bottom).
- text_a / text_b  in  8*CHARS  ASCII; char 0 in [7:0], sent first.
- grant_a / grant_b  out  1  1-cycle pulse when the client's text is captured.
- done_a / done_b  out  1  1-cycle pulse at end of the client's transfer (normal or aborted).
- err  out  1  1-cycle pulse, coincident with done_x, on timeout abort.
- owner  out  2  2'b01 A, 2'b10 B, 2'b00 none.
- lcd_send  out  1  byte-send request to sender.
- lcd_rs  out  1  0 command, 1 data.
- lcd_byte  out  8  byte to sender.
- lcd_busy  in  1  sender busy.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: when lcd_ready=1, lcd_busy=0 and any req is high, choose a winner. On a tie, the client not served last wins; last-served resets to B, so A wins the first tie. Capture text, line and owner; pulse grant_x; clear byte index to 0; go to ISSUE.
- Byte index 0 is the address byte: lcd_rs=0, lcd_byte = 8'h80 for line 0, 8'hC0 for line 1.
- Byte index k (1..CHARS) is snapshot char k-1, with lcd_rs=1.
- ISSUE: lcd_send=1, with lcd_byte and lcd_rs held stable. When lcd_busy is seen high, drop lcd_send and go to DRAIN.
- DRAIN: lcd_send=0. When lcd_busy is seen low, either increment the index and go to ISSUE, or, if the index was CHARS, go to DONE.
- DONE: pulse done_x, record last-served = owner, clear owner, return to IDLE.
- Timeout: a counter clears on every ISSUE/DRAIN entry. If it reaches BUSY_TIMEOUT in either state:
  - drop lcd_send;
  - pulse err together with done_x;
  - update last-served;
  - go to IDLE. The remaining bytes are discarded.
- Snapshot rule: text_x, line_x and req_x may change freely after grant_x with no effect on the running transfer. A req dropped mid-transfer does not abort it.
- A req still high at DONE is re-arbitrated normally; the other client wins if it is also pending.
- lcd_ready falling mid-transfer has no effect; it gates grants only.

## Timing
- Reset (asynchronous, immediate): state IDLE; lcd_send, lcd_rs, grant_*, done_*, err = 0; lcd_byte = 8'h00; owner = 2'b00; last-served = B; counters 0.
- Request to grant: req sampled high in IDLE gives grant_x in the next cycle, and lcd_send=1 in the cycle after grant.
- lcd_send is registered. It deasserts the cycle after lcd_busy is sampled high.
- The next byte's lcd_send asserts the cycle after lcd_busy is sampled low in DRAIN. There is at least 1 cycle of lcd_send=0 between bytes.
- One transfer is exactly CHARS+1 handshakes. With an ideal sender, per-byte overhead is 2 cycles plus the sender's busy time.
- done_x fires 1 cycle after the final busy fall. The earliest next grant is 1 cycle after done_x.

## Test plan
- A alone, line 0, text "HELLO WORLD 1234" → grant_a; bytes 0x80 (rs=0), then 'H','E',…,'4' (rs=1) in order; exactly 17 handshakes; one done_a; err=0; owner returns to 00.
- req_a and req_b rise in the same cycle, B on line 1 → A served fully first; B's first byte is 0xC0. Both held high again → the next tie goes to A (B was last served); after that, B.
- lcd_ready=0 with req_a high for 1000 cycles → no grant and lcd_send stays 0. Raise lcd_ready → grant_a in the next cycle.
- Change text_a and drop req_a 1 cycle after grant_a → the original snapshot is sent intact and done_a is still pulsed.
- Model lcd_busy stuck at 0 with BUSY_TIMEOUT=100 → after 100 cycles in ISSUE, lcd_send drops and err and done_a pulse together; the next request is accepted normally.
- Assert reset_n=0 during the 5th data byte → all outputs return to reset values asynchronously. After release, a new req_a restarts from the address byte.
